// File: rtl/huffman_bit_packer_if.sv
// Stream interface for the Huffman bit packer.
//   Symbol side : sym_valid/sym_data/sym_last in, sym_ready out of the packer.
//   Byte side   : byte_valid/byte_data/byte_last/last_bits out, byte_ready in.
// The master modport is the environment that feeds symbols and consumes
// bytes; the slave modport is the packer itself.
interface huffman_bit_packer_if;
    logic       sym_valid;
    logic [7:0] sym_data;
    logic       sym_last;
    logic       sym_ready;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic [3:0] last_bits;
    logic       byte_ready;

    modport master (
        output sym_valid, sym_data, sym_last, byte_ready,
        input  sym_ready, byte_valid, byte_data, byte_last, last_bits
    );

    modport slave (
        input  sym_valid, sym_data, sym_last, byte_ready,
        output sym_ready, byte_valid, byte_data, byte_last, last_bits
    );
endinterface

// File: rtl/huffman_bit_packer.sv
// Huffman bit packer.
// Latches a six-entry code table (HC1..HC6 code words, M1..M6 length masks)
// on a code_valid pulse, then maps symbols 1..6 to their variable-length
// codes and packs them MSB-first into bytes. Each frame (ended by sym_last)
// is flushed with the final byte zero-padded and tagged with byte_last and
// the number of meaningful bits in last_bits.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   code_valid      one-cycle pulse: HC1..HC6 / M1..M6 are valid
//   HC1..HC6        right-aligned code words
//   M1..M6          contiguous-ones length masks
//   bus (slave)     symbol stream in, byte stream out (see interface)
//   table_ok        a code table has been loaded
//   err_sym         one-cycle pulse after an illegal/zero-length symbol
module huffman_bit_packer #(
    parameter int NSYM  = 6,
    parameter int BUF_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  code_valid,
    input  logic [7:0]            HC1,
    input  logic [7:0]            HC2,
    input  logic [7:0]            HC3,
    input  logic [7:0]            HC4,
    input  logic [7:0]            HC5,
    input  logic [7:0]            HC6,
    input  logic [7:0]            M1,
    input  logic [7:0]            M2,
    input  logic [7:0]            M3,
    input  logic [7:0]            M4,
    input  logic [7:0]            M5,
    input  logic [7:0]            M6,
    huffman_bit_packer_if.slave   bus,
    output logic                  table_ok,
    output logic                  err_sym
);

    localparam int CNT_W = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Number of ones in a length mask gives the code length.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Low-bit mask of the given length, so only HC[L-1:0] is ever appended.
    function automatic logic [7:0] len_mask(input logic [3:0] len);
        logic [7:0] m;
        m = 8'd0;
        for (int i = 0; i < 8; i++) begin
            m[i] = (4'(i) < len);
        end
        return m;
    endfunction

    state_t              state_r, state_n;
    logic [BUF_W-1:0]    buf_r, buf_n;
    logic [CNT_W-1:0]    count_r, count_n;
    logic [7:0]          hc_r [NSYM];
    logic [7:0]          m_r  [NSYM];
    logic [7:0]          hc_in_s [NSYM];
    logic [7:0]          m_in_s  [NSYM];
    logic                table_ok_r;
    logic                err_sym_r, err_sym_n;
    logic                frame_active_r, frame_active_n;
    logic                table_load_s;

    logic                sym_ready_s;
    logic                byte_valid_s;
    logic                byte_last_s;
    logic                accept_s;
    logic                emit_s;
    logic                sym_legal_s;
    logic [2:0]          sym_idx_s;
    logic [3:0]          code_len_s;
    logic [7:0]          code_s;
    logic                sym_err_s;
    logic [BUF_W-1:0]    buf_base_s;
    logic [CNT_W-1:0]    cnt_base_s;
    logic [CNT_W-1:0]    shamt_s;
    logic [BUF_W-1:0]    code_wide_s;

    assign hc_in_s[0] = HC1;
    assign hc_in_s[1] = HC2;
    assign hc_in_s[2] = HC3;
    assign hc_in_s[3] = HC4;
    assign hc_in_s[4] = HC5;
    assign hc_in_s[5] = HC6;
    assign m_in_s[0]  = M1;
    assign m_in_s[1]  = M2;
    assign m_in_s[2]  = M3;
    assign m_in_s[3]  = M4;
    assign m_in_s[4]  = M5;
    assign m_in_s[5]  = M6;

    // Output decode: every output is a function of registers only.
    always_comb begin
        sym_ready_s  = (state_r == ST_RUN) && (count_r <= CNT_W'(8));
        byte_valid_s = (count_r >= CNT_W'(8)) || (state_r == ST_FLUSH);
        byte_last_s  = (state_r == ST_FLUSH) && (count_r <= CNT_W'(8));
    end

    assign bus.sym_ready  = sym_ready_s;
    assign bus.byte_valid = byte_valid_s;
    assign bus.byte_data  = buf_r[BUF_W-1:BUF_W-8];
    assign bus.byte_last  = byte_last_s;
    assign bus.last_bits  = byte_last_s ? count_r[3:0] : 4'd0;
    assign table_ok       = table_ok_r;
    assign err_sym        = err_sym_r;

    assign accept_s = sym_ready_s && bus.sym_valid;
    assign emit_s   = byte_valid_s && bus.byte_ready;

    // Symbol lookup: out-of-range symbols never index the table.
    always_comb begin
        sym_legal_s = (bus.sym_data >= 8'd1) && (bus.sym_data <= 8'(NSYM));
        sym_idx_s   = bus.sym_data[2:0] - 3'd1;
        code_len_s  = 4'd0;
        code_s      = 8'd0;
        if (sym_legal_s) begin
            code_len_s = popcount8(m_r[sym_idx_s]);
            code_s     = hc_r[sym_idx_s] & len_mask(code_len_s);
        end else begin
            code_len_s = 4'd0;
            code_s     = 8'd0;
        end
        sym_err_s = !sym_legal_s || (code_len_s == 4'd0);
    end

    // Accumulator after a same-cycle emit, and the append position relative
    // to it, so accept-and-emit at count==8 lands the code at the top.
    always_comb begin
        if (emit_s) begin
            buf_base_s = buf_r << 8;
            cnt_base_s = count_r - CNT_W'(8);
        end else begin
            buf_base_s = buf_r;
            cnt_base_s = count_r;
        end
        shamt_s     = CNT_W'(BUF_W) - cnt_base_s - CNT_W'(code_len_s);
        code_wide_s = {{(BUF_W-8){1'b0}}, code_s} << shamt_s;
    end

    // Next-state, accumulator and table-load decisions.
    always_comb begin
        state_n        = state_r;
        buf_n          = buf_r;
        count_n        = count_r;
        frame_active_n = frame_active_r;
        err_sym_n      = 1'b0;
        table_load_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (code_valid) begin
                    table_load_s = 1'b1;
                    state_n      = ST_RUN;
                end else begin
                    state_n      = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    frame_active_n = 1'b1;
                    err_sym_n      = sym_err_s;
                    if (sym_err_s) begin
                        buf_n   = buf_base_s;
                        count_n = cnt_base_s;
                    end else begin
                        buf_n   = buf_base_s | code_wide_s;
                        count_n = cnt_base_s + CNT_W'(code_len_s);
                    end
                    if (bus.sym_last) begin
                        state_n = ST_FLUSH;
                    end else begin
                        state_n = ST_RUN;
                    end
                end else begin
                    buf_n   = buf_base_s;
                    count_n = cnt_base_s;
                    // Reload only between frames, so a frame keeps its table.
                    if (code_valid && (count_r == CNT_W'(0)) && !frame_active_r) begin
                        table_load_s = 1'b1;
                    end else begin
                        table_load_s = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                if (emit_s) begin
                    if (count_r <= CNT_W'(8)) begin
                        buf_n          = '0;
                        count_n        = '0;
                        frame_active_n = 1'b0;
                        state_n        = ST_RUN;
                    end else begin
                        buf_n   = buf_r << 8;
                        count_n = count_r - CNT_W'(8);
                    end
                end else begin
                    state_n = ST_FLUSH;
                end
            end
            default: begin
                state_n        = ST_IDLE;
                buf_n          = '0;
                count_n        = '0;
                frame_active_n = 1'b0;
            end
        endcase
    end

    // Control and accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            buf_r          <= '0;
            count_r        <= '0;
            frame_active_r <= 1'b0;
            err_sym_r      <= 1'b0;
        end else begin
            state_r        <= state_n;
            buf_r          <= buf_n;
            count_r        <= count_n;
            frame_active_r <= frame_active_n;
            err_sym_r      <= err_sym_n;
        end
    end

    // Code table storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            table_ok_r <= 1'b0;
            for (int i = 0; i < NSYM; i++) begin
                hc_r[i] <= 8'd0;
                m_r[i]  <= 8'd0;
            end
        end else if (table_load_s) begin
            table_ok_r <= 1'b1;
            for (int i = 0; i < NSYM; i++) begin
                hc_r[i] <= hc_in_s[i];
                m_r[i]  <= m_in_s[i];
            end
        end
    end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed self-checking bench for huffman_bit_packer.
module tb_huffman_bit_packer;

    logic       clk;
    logic       reset;
    logic       code_valid;
    logic [7:0] hc [6];
    logic [7:0] m  [6];
    logic       table_ok;
    logic       err_sym;

    huffman_bit_packer_if bus ();

    huffman_bit_packer dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1        (hc[0]),
        .HC2        (hc[1]),
        .HC3        (hc[2]),
        .HC4        (hc[3]),
        .HC5        (hc[4]),
        .HC6        (hc[5]),
        .M1         (m[0]),
        .M2         (m[1]),
        .M3         (m[2]),
        .M4         (m[3]),
        .M5         (m[4]),
        .M6         (m[5]),
        .bus        (bus.slave),
        .table_ok   (table_ok),
        .err_sym    (err_sym)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] q_data [$];
    logic       q_last [$];
    logic [3:0] q_bits [$];
    int         frames_done = 0;
    int         err_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte/err monitor: at the falling edge, valid&&ready means a handshake
    // happens on the next rising edge.
    always @(negedge clk) begin
        if (bus.byte_valid && bus.byte_ready) begin
            q_data.push_back(bus.byte_data);
            q_last.push_back(bus.byte_last);
            q_bits.push_back(bus.last_bits);
            if (bus.byte_last) frames_done++;
        end
        if (err_sym) err_cnt++;
    end

    task automatic clear_mon();
        q_data.delete();
        q_last.delete();
        q_bits.delete();
        frames_done = 0;
        err_cnt = 0;
    endtask

    task automatic send_sym(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        bus.sym_valid = 1'b1;
        bus.sym_data  = d;
        bus.sym_last  = l;
        @(negedge clk);
        while (!bus.sym_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("sym_accept", {31'd0, bus.sym_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.sym_valid = 1'b0;
        bus.sym_last  = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (frames_done == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("frame_done", frames_done, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic load_table();
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    task automatic check_byte(input string tag, input int i, input logic [7:0] d,
                              input logic l, input logic [3:0] b);
        check_eq({tag, "_data"}, {24'd0, q_data[i]}, {24'd0, d});
        check_eq({tag, "_last"}, {31'd0, q_last[i]}, {31'd0, l});
        check_eq({tag, "_bits"}, {28'd0, q_bits[i]}, {28'd0, b});
    endtask

    initial begin
        reset          = 1'b1;
        code_valid     = 1'b0;
        bus.sym_valid  = 1'b0;
        bus.sym_data   = 8'd0;
        bus.sym_last   = 1'b0;
        bus.byte_ready = 1'b1;
        hc = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
        m  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_table_ok",   {31'd0, table_ok},       32'd0);
        check_eq("rst_sym_ready",  {31'd0, bus.sym_ready},  32'd0);
        check_eq("rst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
        check_eq("rst_byte_last",  {31'd0, bus.byte_last},  32'd0);
        check_eq("rst_last_bits",  {28'd0, bus.last_bits},  32'd0);
        check_eq("rst_err_sym",    {31'd0, err_sym},        32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        load_table();
        check_eq("table_ok", {31'd0, table_ok}, 32'd1);
        check_eq("run_sym_ready", {31'd0, bus.sym_ready}, 32'd1);

        // T1: 0 10 110 1110 -> 0x5B, 0x80 (2 bits)
        clear_mon();
        send_sym(8'd1, 1'b0);
        send_sym(8'd2, 1'b0);
        send_sym(8'd3, 1'b0);
        send_sym(8'd4, 1'b1);
        wait_frame();
        check_eq("t1_nbytes", q_data.size(), 32'd2);
        check_byte("t1_b0", 0, 8'h5B, 1'b0, 4'd0);
        check_byte("t1_b1", 1, 8'h80, 1'b1, 4'd2);

        // T2: 6,6,6 with back-pressure -> 0xFF held, then 0xFE (7 bits)
        clear_mon();
        bus.byte_ready = 1'b0;
        send_sym(8'd6, 1'b0);
        send_sym(8'd6, 1'b0);
        fork
            send_sym(8'd6, 1'b1);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check_eq("t2_stall_ready", {31'd0, bus.sym_ready},  32'd0);
                    check_eq("t2_stall_valid", {31'd0, bus.byte_valid}, 32'd1);
                    check_eq("t2_stall_data",  {24'd0, bus.byte_data},  32'h0000_00FF);
                    check_eq("t2_stall_last",  {31'd0, bus.byte_last},  32'd0);
                end
                @(posedge clk);
                #1;
                bus.byte_ready = 1'b1;
            end
        join
        wait_frame();
        check_eq("t2_nbytes", q_data.size(), 32'd2);
        check_byte("t2_b0", 0, 8'hFF, 1'b0, 4'd0);
        check_byte("t2_b1", 1, 8'hFE, 1'b1, 4'd7);

        // T3: 1,7,1 -> one err pulse, 0x00 (2 bits)
        clear_mon();
        send_sym(8'd1, 1'b0);
        send_sym(8'd7, 1'b0);
        send_sym(8'd1, 1'b1);
        wait_frame();
        check_eq("t3_err_cnt", err_cnt, 32'd1);
        check_eq("t3_nbytes", q_data.size(), 32'd1);
        check_byte("t3_b0", 0, 8'h00, 1'b1, 4'd2);

        // T4: single illegal symbol 9 with last -> 0x00 (0 bits)
        clear_mon();
        send_sym(8'd9, 1'b1);
        wait_frame();
        check_eq("t4_err_cnt", err_cnt, 32'd1);
        check_eq("t4_nbytes", q_data.size(), 32'd1);
        check_byte("t4_b0", 0, 8'h00, 1'b1, 4'd0);

        // T5: mid-frame reload ignored (0 10), later reload used (1 10)
        clear_mon();
        hc[0] = 8'h01;
        send_sym(8'd1, 1'b0);
        load_table();
        send_sym(8'd2, 1'b1);
        wait_frame();
        check_eq("t5a_nbytes", q_data.size(), 32'd1);
        check_byte("t5a_b0", 0, 8'h40, 1'b1, 4'd3);
        clear_mon();
        load_table();
        send_sym(8'd1, 1'b0);
        send_sym(8'd2, 1'b1);
        wait_frame();
        check_eq("t5b_nbytes", q_data.size(), 32'd1);
        check_byte("t5b_b0", 0, 8'hC0, 1'b1, 4'd3);

        // T6: reset mid-frame clears everything; nothing until reload
        clear_mon();
        send_sym(8'd1, 1'b0);
        send_sym(8'd2, 1'b0);
        send_sym(8'd3, 1'b0);
        reset = 1'b1;
        #1;
        check_eq("t6_table_ok",   {31'd0, table_ok},       32'd0);
        check_eq("t6_sym_ready",  {31'd0, bus.sym_ready},  32'd0);
        check_eq("t6_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
        check_eq("t6_byte_last",  {31'd0, bus.byte_last},  32'd0);
        check_eq("t6_last_bits",  {28'd0, bus.last_bits},  32'd0);
        check_eq("t6_err_sym",    {31'd0, err_sym},        32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.sym_valid = 1'b1;
        bus.sym_data  = 8'd1;
        bus.sym_last  = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("t6_idle_ready", {31'd0, bus.sym_ready}, 32'd0);
        check_eq("t6_no_bytes", q_data.size(), 32'd0);
        bus.sym_valid = 1'b0;
        bus.sym_last  = 1'b0;
        hc[0] = 8'h00;
        load_table();
        send_sym(8'd1, 1'b1);
        wait_frame();
        check_eq("t6_nbytes", q_data.size(), 32'd1);
        check_byte("t6_b0", 0, 8'h00, 1'b1, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/huffman_bit_packer.md
Name: huffman_bit_packer

Overview:
- Downstream of the Huffman code-table builder.
- Latches the six-entry code table (HC1..HC6 with masks M1..M6) when code_valid pulses.
- Maps a stream of gray-level symbols (1..6) to their variable-length codes and packs the bits MSB-first into 8-bit output bytes.
- Uses valid/ready handshakes on both sides and zero-pads the final byte of each frame.

Parameters:
- NSYM, 6, number of code-table entries (fixed by builder interface).
- BUF_W, 16, bit-accumulator width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- code_valid  input  1  one-cycle pulse; HC/M table valid
- HC1..HC6  input  8 each  code word per symbol, right-aligned
- M1..M6  input  8 each  code-length mask, contiguous ones from bit 0
- sym_valid  input  1  symbol present
- sym_data  input  8  symbol value
- sym_last  input  1  symbol is last of frame
- sym_ready  output  1  packer accepts symbol this cycle
- byte_valid  output  1  packed byte present
- byte_data  output  8  packed byte, first bit in bit 7
- byte_last  output  1  final byte of frame
- last_bits  output  4  valid bits in byte_last byte (0..8); 0 when byte_last=0
- byte_ready  input  1  consumer accepts byte
- table_ok  output  1  table loaded
- err_sym  output  1  one-cycle pulse: illegal or zero-length symbol dropped

Behaviour:
- Reset (async): state=IDLE; table cleared; table_ok=0; buf=0; count=0; sym_ready=0; byte_valid=0; byte_last=0; last_bits=0; err_sym=0.
- Code length: L = popcount(Mn), range 0..8. Code bits are HCn[L-1:0], transmitted bit L-1 first.
- Accumulator: buf[15:0] holds bits left-aligned; count (0..16) is the number of valid bits.
- Append: buf |= code << (16-count-L); count += L.
- Emit: byte_data = buf[15:8]; on handshake buf <<= 8, count -= 8.
- States:
  - IDLE: waits for code_valid. On code_valid, latch all HC/M, set table_ok=1, go to RUN.
  - RUN: sym_ready = (count<=8). Accepting with sym_last=1 goes to FLUSH.
  - FLUSH: sym_ready=0. Drain remaining bits, then return to RUN with count=0 and buf=0.
- Byte output:
  - byte_valid = (count>=8) || (state==FLUSH).
  - byte_last = FLUSH && count<=8.
  - last_bits = count when byte_last, else 0.
  - Remaining low bits of the last byte are zero.
- Simultaneous events:
  - At count==8 in RUN, accept and emit in the same cycle are allowed: count_next = count - 8 + L.
  - While byte_valid=1 and byte_ready=0, byte_data, byte_last and last_bits hold stable.
- Error symbols:
  - sym_data outside 1..6, or L=0: consumed (sym_ready honoured), nothing appended, err_sym pulses the next cycle.
  - sym_last on an error symbol still ends the frame.
  - A frame that ends with count==0 emits one 0x00 byte with byte_last=1 and last_bits=0.
- Table reload: code_valid in RUN with count==0 and no frame in progress (no symbol accepted since the last flush) reloads the table. Otherwise code_valid is ignored. The current frame always uses the table it started with.
- Reset mid-frame: everything cleared; partial bits discarded; table must be reloaded.
- All outputs registered or decoded from registers only; no combinational path from byte_ready or sym_valid to outputs.

Test Plan:
- Load table: HC1=0/M=01, HC2=02/03, HC3=06/07, HC4=0E/0F, HC5=1E/1F, HC6=1F/1F. Send symbols 1,2,3,4 (last on 4), byte_ready=1 -> bytes 0x5B, then 0x80 with byte_last=1, last_bits=2.
- Same table; symbols 6,6,6 (last); hold byte_ready=0 for 5 cycles -> sym_ready=0 once count=10 (after the second symbol), byte_data held at 0xFF. On release: 0xFF, then 0xFE with byte_last, last_bits=7.
- Symbols 1,7,1 (last) -> err_sym pulses once for symbol 7; output 0x00 with byte_last=1, last_bits=2.
- Single symbol 9 with last -> err_sym=1; one byte 0x00 with byte_last=1, last_bits=0.
- code_valid pulse with a modified HC1 mid-frame -> ignored, frame output unchanged. Same pulse after the flush -> new table used by the next frame.
- Assert reset after 3 symbols accepted -> all outputs 0 within the reset cycle, table_ok=0, no bytes emitted until the table is reloaded.
